// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a FIFO, issues them one at a time and hands results downstream.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int OPW = 2,
  parameter int RESW = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OPW-1:0]           cmd_a,
  input  logic [OPW-1:0]           cmd_b,
  input  logic [3:0]               cmd_sel,
  output logic [OPW-1:0]           alu_a,
  output logic [OPW-1:0]           alu_b,
  output logic [3:0]               alu_sel,
  input  logic [RESW-1:0]          alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RESW-1:0]          res_data,
  output logic [3:0]               res_op,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               done_cnt,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4 + 2 * OPW;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUTPUT} state_t;
  state_t r_state, w_next;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count;
  logic w_push, w_pop, w_done;
  logic [EW-1:0] w_head;
  assign cmd_ready = r_count != (AW+1)'(DEPTH);
  assign fifo_count = r_count;
  assign w_push = cmd_valid & cmd_ready;
  assign w_head = r_mem[r_rd_ptr];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= {cmd_sel, cmd_b, cmd_a};
  always_ff @(posedge clk)
    if (res) r_state <= IDLE;
    else r_state <= w_next;
  // Pop decision uses the registered count, so a fresh push is never popped on its own edge.
  always_comb begin
    w_pop = (r_state == IDLE) && (r_count != '0);
    w_done = (r_state == OUTPUT) && res_ready;
    res_valid = r_state == OUTPUT;
    busy = r_state != IDLE;
    w_next = r_state == IDLE    ? (w_pop ? ISSUE : IDLE) :
             r_state == ISSUE   ? CAPTURE :
             r_state == CAPTURE ? OUTPUT :
             (res_ready ? IDLE : OUTPUT);
  end
  always_ff @(posedge clk)
    if (res) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      res_op <= '0;
      res_data <= '0;
      done_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        alu_a <= w_head[OPW-1:0];
        alu_b <= w_head[2*OPW-1:OPW];
        alu_sel <= w_head[EW-1:2*OPW];
        res_op <= w_head[EW-1:2*OPW];
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (r_state == CAPTURE) res_data <= alu_out;
      if (w_done) done_cnt <= done_cnt + 8'd1;
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench with a behavioural registered 2-bit ALU behind the sequencer.
module tb_alu_cmd_sequencer;
  logic clk = 0, res = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b;
  logic [3:0] cmd_sel = 0, alu_sel, alu_out, res_data, res_op;
  logic res_valid, res_ready = 1, busy;
  logic [2:0] fifo_count;
  logic [7:0] done_cnt;
  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [7:0] q[$];
  logic prev_hold = 0;
  logic [7:0] prev = 0;

  alu_cmd_sequencer #(.DEPTH(4), .OPW(2), .RESW(4)) dut (
    .clk(clk), .res(res), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
    .fifo_count(fifo_count), .done_cnt(done_cnt), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the ALU: 1 add, 2 A-B, 3 B-A, 4 A*B, anything else A+B; output registered.
  always @(posedge clk)
    case (alu_sel)
      4'd2: alu_out <= 4'(alu_a) - 4'(alu_b);
      4'd3: alu_out <= 4'(alu_b) - 4'(alu_a);
      4'd4: alu_out <= 4'(alu_a) * 4'(alu_b);
      default: alu_out <= 4'(alu_a) + 4'(alu_b);
    endcase

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (res) prev_hold = 0;
    else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(res_valid), 32'd1);
        chk("hold_data", 32'({res_op, res_data}), 32'(prev));
      end
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got %0h expected none", {res_op, res_data});
        end else chk("result", 32'({res_op, res_data}), 32'(q.pop_front()));
      end
      prev_hold = res_valid && !res_ready;
      prev = {res_op, res_data};
    end
  end

  task automatic push(input logic [1:0] a, input logic [1:0] b, input logic [3:0] s,
                      input logic [3:0] exp, output logic acc);
    @(negedge clk);
    cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_sel = s;
    acc = cmd_ready;
    @(posedge clk);
    if (acc) q.push_back({s, exp});
    #1 cmd_valid = 0;
  endtask

  task automatic wait_idle(input int limit);
    logic ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = !busy && fifo_count == 0 && q.size() == 0;
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1;
    q.delete();
    @(negedge clk);
    res = 0;
  endtask

  initial begin
    logic acc;
    int n_acc, t[5];
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int n_acc, sent;
    int t[5];
    logic got;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_busy_ready", 32'({busy, cmd_ready}), 32'b01);
    chk("rst_regs", 32'({alu_a, alu_b, alu_sel, res_data, res_op, done_cnt}), 0);
    res = 0;
    push(2'd3, 2'd1, 4'd1, 4'd4, acc);
    @(posedge clk); @(negedge clk);
    chk("lat_e1_valid", 32'(res_valid), 0);
    chk("lat_e1_busy", 32'(busy), 1);
    @(posedge clk); @(negedge clk);
    chk("lat_e2_valid", 32'(res_valid), 0);
    @(posedge clk); @(negedge clk);
    chk("lat_e3_valid", 32'(res_valid), 1);
    wait_idle(20);
    chk("done_1", 32'(done_cnt), 1);
    push(2'd3, 2'd3, 4'd4, 4'd9, acc);
    wait_idle(20);
    push(2'd1, 2'd3, 4'd2, 4'hE, acc);
    wait_idle(20);
    push(2'd1, 2'd3, 4'd3, 4'd2, acc);
    wait_idle(20);
    chk("done_4", 32'(done_cnt), 4);

    do_reset();
    @(negedge clk) res_ready = 0;
    n_acc = 0;
    push(2'd0, 2'd1, 4'd1, 4'd1, acc); n_acc += int'(acc);
    push(2'd1, 2'd2, 4'd1, 4'd3, acc); n_acc += int'(acc);
    push(2'd3, 2'd2, 4'd4, 4'd6, acc); n_acc += int'(acc);
    push(2'd2, 2'd3, 4'd2, 4'hF, acc); n_acc += int'(acc);
    push(2'd0, 2'd3, 4'd3, 4'd3, acc); n_acc += int'(acc);
    push(2'd3, 2'd3, 4'd1, 4'd6, acc); n_acc += int'(acc);
    push(2'd1, 2'd1, 4'd4, 4'd1, acc); n_acc += int'(acc);
    push(2'd2, 2'd2, 4'd2, 4'd0, acc); n_acc += int'(acc);
    push(2'd3, 2'd1, 4'd3, 4'hE, acc); n_acc += int'(acc);
    chk("accepted", 32'(n_acc), 5);
    @(negedge clk);
    chk("full_count", 32'(fifo_count), 4);
    chk("full_ready", 32'(cmd_ready), 0);
    chk("bp_valid", 32'(res_valid), 1);
    repeat (4) @(negedge clk);
    res_ready = 1;
    for (int k = 0; k < 5; k++) begin
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        if (res_valid) got = 1;
        else @(negedge clk);
      end
      chk("drain_timeout", 32'(got), 1);
      t[k] = cyc;
      @(negedge clk);
    end
    for (int k = 1; k < 5; k++) chk("drain_gap", 32'(t[k] - t[k-1]), 4);
    wait_idle(20);
    chk("done_5", 32'(done_cnt), 5);

    push(2'd1, 2'd1, 4'd1, 4'd2, acc);
    push(2'd2, 2'd1, 4'd1, 4'd3, acc);
    push(2'd3, 2'd1, 4'd1, 4'd4, acc);
    @(negedge clk);
    res = 1;
    q.delete();
    @(negedge clk);
    res = 0;
    chk("mid_rst_valid", 32'(res_valid), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done_cnt), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    repeat (12) @(negedge clk);
    chk("mid_rst_quiet", 32'({res_valid, busy, fifo_count}), 0);

    sent = 0;
    for (int i = 0; i < 2000 && sent < 256; i++) begin
      push(2'd1, 2'd1, 4'd1, 4'd2, acc);
      sent += int'(acc);
    end
    chk("wrap_sent", 32'(sent), 256);
    wait_idle(40);
    chk("wrap_done", 32'(done_cnt), 0);
    push(2'd2, 2'd1, 4'd0, 4'd3, acc);
    wait_idle(20);
    chk("sel0_done", 32'(done_cnt), 1);
    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream command stage for the 2-bit registered ALU. It buffers operand/opcode commands in a small FIFO and issues them to the ALU one at a time. It then captures the ALU's registered result on the correct cycle and presents it downstream with a valid/ready handshake. It lets a front end (switch/button logic, UART decoder) push commands without tracking ALU timing.

Parameters:
DEPTH, 4, command FIFO depth in entries; must be a power of 2, at least 2
OPW, 2, operand width; matches ALU A/B width
RESW, 4, result width; matches ALU out width

Ports:
clk  in  1  system clock, rising edge
res  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_a  in  OPW  operand A
cmd_b  in  OPW  operand B
cmd_sel  in  4  ALU opcode
alu_a  out  OPW  to ALU A
alu_b  out  OPW  to ALU B
alu_sel  out  4  to ALU select
alu_out  in  RESW  from ALU out
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_data  out  RESW  captured result
res_op  out  4  opcode that produced res_data
fifo_count  out  clog2(DEPTH)+1  entries currently buffered
done_cnt  out  8  completed results, wraps
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: synchronous, res=1 sampled at the rising edge of clk.
  - Reset values: alu_a, alu_b, alu_sel, res_data, res_op, done_cnt, fifo_count = 0; res_valid = 0; busy = 0; cmd_ready = 1; FSM = IDLE; FIFO pointers = 0.
  - Reset mid-operation discards the FIFO contents and any in-flight or held result.
  - The ALU's own reset is driven by the top level, not by this block.
- FIFO:
  - Push when cmd_valid & cmd_ready. cmd_ready = (fifo_count != DEPTH).
  - cmd_valid while full is ignored; nothing is written.
  - Push and pop on the same edge leave fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if fifo_count != 0, pop the head. Load alu_a/alu_b/alu_sel and res_op from it, then go to ISSUE. Otherwise stay.
  - ISSUE: operands are stable at the ALU for exactly this cycle. The ALU registers them at the end of the cycle. Go to CAPTURE.
  - CAPTURE: alu_out holds the result. Register res_data <= alu_out, then go to OUTPUT.
  - OUTPUT: res_valid = 1. res_data and res_op are held stable until res_ready = 1.
    - On the handshake edge: done_cnt += 1 (wraps 255->0), then go to IDLE.
- Timing and throughput:
  - A command pushed at edge E0 into an empty FIFO with FSM idle gives res_valid high after edge E0+3.
  - Maximum throughput is one result per 4 cycles.
  - The pop in IDLE uses the registered fifo_count, so a command is never pushed and popped on the same edge.
- alu_a, alu_b, alu_sel are registers. They keep their last values outside IDLE-load; the ALU recomputes the same result harmlessly.
- Opcodes pass through unfiltered. sel=0 is issued as-is, and the ALU default gives A+B.
- Result width follows the ALU's 4-bit arithmetic. Subtraction underflow wraps, e.g. 1-3 = 4'hE. The sequencer does no result arithmetic.
- busy = (state != IDLE).
- The FIFO keeps accepting while the FSM is in any state.

Test Plan:
- Basic ops:
  - push {A=3, B=1, sel=1}, res_ready=1 -> res_valid after edge E0+3, res_data=4, res_op=1, done_cnt=1.
  - then {A=3, B=3, sel=4} -> res_data=9.
- Underflow: push {A=1, B=3, sel=2} -> res_data=4'hE. Then push {A=1, B=3, sel=3} -> res_data=2.
- Backpressure:
  - res_ready=0, push 6 commands back-to-back -> exactly 5 accepted.
  - cmd_ready=0 once fifo_count=4.
  - res_valid stays 1 with res_data constant.
  - Then res_ready=1 -> 5 results in push order, each separated by 4 cycles, done_cnt=5.
- Push while full: hold cmd_valid=1 with FIFO full and changing data -> no overwrite; results match only the accepted commands.
- Reset mid-operation: assert res=1 for one cycle while in CAPTURE with 2 entries queued -> next cycle res_valid=0, fifo_count=0, busy=0, done_cnt=0, cmd_ready=1; no stale result appears afterwards.
- done_cnt wrap: complete 256 commands -> done_cnt reads 0; sel=0 command {A=2, B=1} -> res_data=3.
